matrix_keypad_scanner: RTL and testbench
========================================

MATRIX_KEYPAD_SCANNER -- requirements
Module: matrix_keypad_scanner

Interface
REQ-001 Parameter ROWS, default 4, number of driven keypad rows (>=2).
REQ-002 Parameter COLS, default 4, number of sensed keypad columns (>=2).
REQ-003 Parameter SCAN_DIV, default 50000, clock cycles each row stays driven during scanning (>=2).
REQ-004 Parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required for press and for release (>=2).
REQ-005 clk  input  1  single system clock; all logic on posedge clk.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 col_sense  input  COLS  raw asynchronous column levels, active-high (pressed key on driven row reads 1).
REQ-008 key_ready  input  1  consumer accepts key_code this cycle.
REQ-009 row_drive  output  ROWS  one-hot, active-high row select.
REQ-010 key_code  output  clog2(ROWS*COLS)  code of pending key, row*COLS+col.
REQ-011 key_valid  output  1  key_code holds an unconsumed key.
REQ-012 key_overrun  output  1  sticky flag: a debounced key was dropped because key_valid was still high.

Function
REQ-013 col_sense SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (col_s).
REQ-014 FSM states SHALL be SCAN, DEBOUNCE, WAIT_RELEASE.
REQ-015 SCAN: row_drive SHALL rotate one position toward the next row index every SCAN_DIV cycles, wrapping from row ROWS-1 to row 0.
REQ-016 SCAN: on the last dwell cycle of a row, if col_s is nonzero, the row index and the lowest-index set column SHALL be latched, row_drive frozen, dwell counter cleared, and the state SHALL go to DEBOUNCE.
REQ-017 DEBOUNCE: the counter SHALL increment each cycle the latched column bit of col_s is 1; if that bit is 0, the state SHALL return to SCAN and rotate to the next row on the following cycle.
REQ-018 DEBOUNCE completion (DEBOUNCE_CYCLES consecutive 1s): if key_valid is 0, or key_valid&&key_ready in the same cycle, key_code SHALL load row*COLS+col and key_valid SHALL be 1 next cycle; otherwise key_overrun SHALL set and key_code SHALL be unchanged; in both cases the state SHALL go to WAIT_RELEASE.
REQ-019 WAIT_RELEASE: row_drive SHALL stay frozen; after DEBOUNCE_CYCLES consecutive cycles with the latched column bit 0, the state SHALL return to SCAN and advance to the next row; any 1 SHALL restart the count.
REQ-020 Handshake: key_valid SHALL clear the cycle after key_valid&&key_ready unless a new key loads in that same cycle (REQ-018); key_code SHALL be stable while key_valid is 1.
REQ-021 key_ready while key_valid is 0 SHALL have no effect.
REQ-022 Multiple simultaneous keys: only the lowest column on the first scanned row SHALL be reported; others are ignored until release.
REQ-023 key_overrun SHALL stay 1 until reset.
REQ-024 Worst-case press-to-key_valid latency SHALL be 2 + ROWS*SCAN_DIV + DEBOUNCE_CYCLES + 1 cycles.

Reset
REQ-025 On reset: row_drive=1 (row 0), key_valid=0, key_code=0, key_overrun=0, state SCAN, all counters and synchronizer flops 0.
REQ-026 Reset asserted mid-DEBOUNCE or mid-WAIT_RELEASE SHALL discard the latched key with no key_valid pulse; scanning SHALL restart at row 0.

Structure
REQ-027 Package keypad_pkg SHALL hold the FSM state encoding and width constants (code width, counter widths derived via clog2).
REQ-028 A sub-module sync_2ff (parameterized width, synchronous reset) SHALL implement REQ-013; the row ring, counters and FSM stay in the top module.

Verification (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_CYCLES=8)
REQ-029 Reset, no keys: row_drive cycles 0001->0010->0100->1000->0001, 4 cycles per row; key_valid stays 0.
REQ-030 Hold row2/col1 for 40 cycles with key_ready=0: key_code=9, key_valid=1 and held; after key_ready pulse, key_valid=0 next cycle; release yields no further key.
REQ-031 Bounce: row1/col3 asserted for 5 cycles then dropped, repeated 3 times: no key_valid; scanning resumes with row2.
REQ-032 Press row0/col0, do not consume, release, press row3/col2: key_code stays 0, key_overrun=1.
REQ-033 Simultaneous consume: second key's debounce completes in the cycle key_valid&&key_ready is high: key_valid stays 1, key_code updates, key_overrun stays 0.
REQ-034 Reset asserted during DEBOUNCE of row1/col2: no key_valid; row_drive=0001 the cycle after reset.

Source files
------------

// File: rtl/matrix_keypad_scanner_pkg.sv
// Shared definitions for the matrix keypad scanner: FSM state encoding
// and the helper used to size codes and counters from the parameters.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        WAIT_RELEASE
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned width_for(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matrix_keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/matrix_keypad_scanner.sv
// Row-scanning keypad controller: rotates a one-hot row drive, debounces
// press and release of one key at a time, and offers it on a valid/ready port.
module matrix_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS            = 4,
    parameter int unsigned COLS            = 4,
    parameter int unsigned SCAN_DIV        = 50000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [COLS-1:0]                     col_sense,
    input  logic                                key_ready,
    output logic [ROWS-1:0]                     row_drive,
    output logic [width_for(ROWS*COLS)-1:0]     key_code,
    output logic                                key_valid,
    output logic                                key_overrun
);

    localparam int unsigned CODE_W  = width_for(ROWS * COLS);
    localparam int unsigned ROW_W   = width_for(ROWS);
    localparam int unsigned COL_W   = width_for(COLS);
    localparam int unsigned DWELL_W = width_for(SCAN_DIV);
    localparam int unsigned DEB_W   = width_for(DEBOUNCE_CYCLES);

    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic [COLS-1:0]    col_s;
    state_t             state;
    logic [ROW_W-1:0]   row_idx;
    logic [ROW_W-1:0]   next_row_idx;
    logic [COL_W-1:0]   key_col;
    logic [COL_W-1:0]   low_col;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DEB_W-1:0]   deb_cnt;
    logic [CODE_W-1:0]  new_code;
    logic               col_hit;

    sync_2ff #(.WIDTH(COLS)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (col_sense),
        .q     (col_s)
    );

    always_comb begin
        logic found;
        found   = 1'b0;
        low_col = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (col_s[i] && !found) begin
                low_col = COL_W'(i);
                found   = 1'b1;
            end
        end
    end

    assign next_row_idx = (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
    assign col_hit      = col_s[key_col];
    assign new_code     = CODE_W'(int'(row_idx) * int'(COLS) + int'(key_col));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SCAN;
            row_idx     <= '0;
            row_drive   <= ROWS'(1);
            dwell_cnt   <= '0;
            deb_cnt     <= '0;
            key_col     <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_overrun <= 1'b0;
        end else begin
            // A load in DEBOUNCE below overrides this clear in the same cycle.
            if (key_valid && key_ready)
                key_valid <= 1'b0;

            case (state)
                SCAN: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt <= '0;
                        if (|col_s) begin
                            key_col <= low_col;
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            row_idx   <= next_row_idx;
                            row_drive <= {row_drive[ROWS-2:0], row_drive[ROWS-1]};
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end

                DEBOUNCE: begin
                    if (!col_hit) begin
                        deb_cnt   <= '0;
                        state     <= SCAN;
                        row_idx   <= next_row_idx;
                        row_drive <= {row_drive[ROWS-2:0], row_drive[ROWS-1]};
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt <= '0;
                        state   <= WAIT_RELEASE;
                        if (!key_valid || key_ready) begin
                            key_code  <= new_code;
                            key_valid <= 1'b1;
                        end else begin
                            key_overrun <= 1'b1;
                        end
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                WAIT_RELEASE: begin
                    if (col_hit) begin
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        deb_cnt   <= '0;
                        state     <= SCAN;
                        row_idx   <= next_row_idx;
                        row_drive <= {row_drive[ROWS-2:0], row_drive[ROWS-1]};
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Directed bench for matrix_keypad_scanner with a 4x4 keypad model,
// SCAN_DIV=4 and DEBOUNCE_CYCLES=8.
module tb_matrix_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] col_sense;
    logic       key_ready;
    logic [3:0] row_drive;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_overrun;
    logic [15:0] keys;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    matrix_keypad_scanner #(
        .ROWS            (4),
        .COLS            (4),
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .col_sense   (col_sense),
        .key_ready   (key_ready),
        .row_drive   (row_drive),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_overrun (key_overrun)
    );

    always #5 clk = ~clk;

    // Keypad: a held key connects its row line to its column line.
    always_comb begin
        col_sense = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (row_drive[r] && keys[r*4+c])
                    col_sense[c] = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic run_cycles(input int n, output logic any_valid, output logic all_valid);
        any_valid = 1'b0;
        all_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            any_valid = any_valid | key_valid;
            all_valid = all_valid & key_valid;
        end
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !key_valid; i++)
            @(negedge clk);
    endtask

    // Returns at the first negedge of a fresh dwell on the target row.
    task automatic wait_row_entry(input logic [3:0] target, input string tag);
        for (int i = 0; i < 60 && row_drive == target; i++)
            @(negedge clk);
        for (int i = 0; i < 60 && row_drive != target; i++)
            @(negedge clk);
        check(tag, row_drive, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic any_v, all_v, any_acc;
        logic [3:0] exp_row;

        reset     = 1'b1;
        keys      = '0;
        key_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state and idle row rotation, 4 cycles per row
        reset = 1'b0;
        check("rst_row", row_drive, 4'b0001);
        check("rst_valid", key_valid, 1'b0);
        check("rst_code", key_code, 4'd0);
        check("rst_overrun", key_overrun, 1'b0);
        any_acc = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            exp_row = 4'b0001 << ((i / 4) % 4);
            check("scan_row", row_drive, exp_row);
            any_acc = any_acc | key_valid;
        end
        check("scan_no_valid", any_acc, 1'b0);

        // Row2/col1 held: code 9, held until consumed, no repeat on release
        keys[9] = 1'b1;
        wait_valid(60);
        check("t2_valid", key_valid, 1'b1);
        check("t2_code", key_code, 4'd9);
        run_cycles(12, any_v, all_v);
        check("t2_held", all_v, 1'b1);
        check("t2_code_held", key_code, 4'd9);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        check("t2_consumed", key_valid, 1'b0);
        keys[9] = 1'b0;
        run_cycles(60, any_v, all_v);
        check("t2_no_repeat", any_v, 1'b0);

        // Row1/col3 bouncing for 5 cycles, three times
        any_acc = 1'b0;
        for (int rep = 0; rep < 3; rep++) begin
            wait_row_entry(4'b0010, "t3_row1");
            keys[7] = 1'b1;
            run_cycles(5, any_v, all_v);
            any_acc = any_acc | any_v;
            keys[7] = 1'b0;
            for (int i = 0; i < 30 && row_drive == 4'b0010; i++)
                @(negedge clk);
            check("t3_resume_row2", row_drive, 4'b0100);
        end
        run_cycles(10, any_v, all_v);
        check("t3_no_valid", any_acc | any_v, 1'b0);

        // Overrun: unconsumed key 0, then key 14
        keys[0] = 1'b1;
        wait_valid(60);
        check("t4_valid", key_valid, 1'b1);
        check("t4_code0", key_code, 4'd0);
        keys[0] = 1'b0;
        run_cycles(40, any_v, all_v);
        check("t4_no_overrun_yet", key_overrun, 1'b0);
        keys[14] = 1'b1;
        for (int i = 0; i < 80 && !key_overrun; i++)
            @(negedge clk);
        check("t4_overrun", key_overrun, 1'b1);
        check("t4_code_kept", key_code, 4'd0);
        check("t4_valid_kept", key_valid, 1'b1);
        keys[14] = 1'b0;
        run_cycles(40, any_v, all_v);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        check("t4_consumed", key_valid, 1'b0);
        check("t4_sticky", key_overrun, 1'b1);

        // Reset mid-DEBOUNCE of row1/col2
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t5_rst_overrun", key_overrun, 1'b0);
        check("t5_rst_row", row_drive, 4'b0001);
        keys[6] = 1'b1;
        wait_row_entry(4'b0010, "t5_row1");
        run_cycles(6, any_v, all_v);
        check("t5_frozen", row_drive, 4'b0010);
        reset   = 1'b1;
        keys[6] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("t5_row_after_rst", row_drive, 4'b0001);
        check("t5_valid_after_rst", key_valid, 1'b0);
        run_cycles(40, any_v, all_v);
        check("t5_no_valid", any_v, 1'b0);

        // Consume in the very cycle the next key's debounce completes
        keys[1] = 1'b1;
        wait_valid(60);
        check("t6_first_code", key_code, 4'd1);
        keys[1] = 1'b0;
        run_cycles(40, any_v, all_v);
        wait_row_entry(4'b0001, "t6_row0");
        keys[11] = 1'b1;
        wait_row_entry(4'b0100, "t6_row2");
        run_cycles(11, any_v, all_v);
        check("t6_pre_valid", key_valid, 1'b1);
        check("t6_pre_code", key_code, 4'd1);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
        check("t6_valid", key_valid, 1'b1);
        check("t6_code", key_code, 4'd11);
        check("t6_no_overrun", key_overrun, 1'b0);
        keys = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
